neuron_accum: RTL and testbench

Sequential weight-fetch and integrate stage for one spiking neuron, sitting directly downstream of the synaptic weight RAM (registered-address, single-port). On a start pulse it latches an input spike vector, then walks the RAM address from `BASE_ADDR` through `BASE_ADDR+NUM_INPUTS-1`. For every input whose spike bit is set, it adds the corresponding signed weight to a saturating accumulator. The final sum is compared against a threshold to produce one output spike and a one-cycle `done` pulse.

---
 rtl/neuron_accum.sv | 146 ++++++++++++++
 tb/tb_neuron_accum.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accum.sv
// Weight-fetch and integrate stage for one spiking neuron: streams one weight per
// cycle from a registered-address RAM, accumulates gated weights with saturation.
module neuron_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_INPUTS = 64,
    parameter int ACC_WIDTH  = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_INPUTS-1:0] spikes_in,
    input  logic [ACC_WIDTH-1:0]  threshold,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  spike_out,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIRE  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(NUM_INPUTS + 1) + 1;
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(NUM_INPUTS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_INPUTS-1:0]   spikes_q, spikes_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    spike_out_q, spike_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ACC_WIDTH:0]      sum_w;
    logic [ACC_WIDTH-1:0]    acc_sat;
    logic                    acc_en;

    // One extra sign bit exposes overflow; clip instead of wrapping.
    always_comb begin
        sum_w = {acc_q[ACC_WIDTH-1], acc_q}
              + {{(ACC_WIDTH+1-DATA_WIDTH){ram_q[DATA_WIDTH-1]}}, ram_q};
        if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
            acc_sat = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = sum_w[ACC_WIDTH-1:0];
        end
    end

    // Handshake: start is accepted only on an edge where busy is low; while busy is
    // high start is ignored (not queued). done pulses once per accepted start.
    // Data for the address issued after edge k is consumed at edge k+2, so the
    // first word arrives once cnt_q has left 0 and the last one lands in DRAIN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        spikes_d    = spikes_q;
        acc_d       = acc_q;
        spike_out_d = spike_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        acc_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    spikes_d    = spikes_in;
                    acc_d       = '0;
                    spike_out_d = 1'b0;
                    addr_d      = ADDR_WIDTH'(BASE_ADDR);
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d  = cnt_q + CNT_W'(1);
                acc_en = (cnt_q != '0);
                if (cnt_q != LAST_IDX) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_en  = 1'b1;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                spike_out_d = ($signed(acc_q) >= $signed(threshold));
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Spike bits are consumed LSB-first, one per arriving word.
        if (acc_en) begin
            if (spikes_q[0]) begin
                acc_d = acc_sat;
            end
            spikes_d = spikes_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            spikes_q    <= '0;
            acc_q       <= '0;
            spike_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            spikes_q    <= spikes_d;
            acc_q       <= acc_d;
            spike_out_q <= spike_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign acc       = acc_q;
    assign spike_out = spike_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_neuron_accum.sv
// Bench for neuron_accum: a small N=4 / 9-bit instance for directed timing cases and
// a wide N=64 / 12-bit instance at a non-zero base address for randomized runs.
module tb_neuron_accum;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Small instance
    logic       start_a;
    logic [3:0] spikes_a;
    logic [8:0] th_a;
    logic [7:0] addr_a;
    logic [7:0] q_a;
    logic       busy_a, done_a, spk_a;
    logic [8:0] acc_a;
    logic [1:0] dbg_a;
    logic [7:0] ram_a [0:255];

    // Wide instance
    logic        start_b;
    logic [63:0] spikes_b;
    logic [11:0] th_b;
    logic [7:0]  addr_b;
    logic [7:0]  q_b;
    logic        busy_b, done_b, spk_b;
    logic [11:0] acc_b;
    logic [1:0]  dbg_b;
    logic [7:0]  ram_b [0:255];

    always @(posedge clk) q_a <= ram_a[addr_a];
    always @(posedge clk) q_b <= ram_b[addr_b];

    neuron_accum #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_INPUTS(4), .ACC_WIDTH(9),
                   .BASE_ADDR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .spikes_in(spikes_a),
        .threshold(th_a), .ram_addr(addr_a), .ram_q(q_a), .busy(busy_a),
        .done(done_a), .acc(acc_a), .spike_out(spk_a), .dbg_state(dbg_a)
    );

    neuron_accum #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_INPUTS(64), .ACC_WIDTH(12),
                   .BASE_ADDR(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .spikes_in(spikes_b),
        .threshold(th_b), .ram_addr(addr_b), .ram_q(q_b), .busy(busy_b),
        .done(done_b), .acc(acc_b), .spike_out(spk_b), .dbg_state(dbg_b)
    );

    // Reference: plain saturating sum of the gated weights, clipping after each add.
    function automatic int integrate(input logic [63:0] spk, input int n, input int base,
                                     input int accw, input bit use_b);
        int sum = 0;
        int lo = -(1 <<< (accw - 1));
        int hi = (1 <<< (accw - 1)) - 1;
        int w;
        for (int i = 0; i < n; i++) begin
            if (spk[i]) begin
                w = use_b ? int'($signed(ram_b[base + i])) : int'($signed(ram_a[base + i]));
                sum = sum + w;
                if (sum > hi) sum = hi;
                if (sum < lo) sum = lo;
            end
        end
        return sum;
    endfunction

    task automatic load_basic_a();
        ram_a[0] = 8'h05; ram_a[1] = 8'hFE; ram_a[2] = 8'h7F; ram_a[3] = 8'h80;
    endtask

    task automatic wait_done_a(input string name);
        bit got = 0;
        int c = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            got = done_a;
            c++;
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, c);
        end
    endtask

    task automatic wait_done_b(input string name);
        bit got = 0;
        int c = 0;
        while (!got && c < 200) begin
            @(negedge clk);
            got = done_b;
            c++;
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, c);
        end
    endtask

    task automatic do_run_a(input logic [3:0] s, input logic [8:0] th, input string name);
        @(negedge clk);
        start_a = 1'b1; spikes_a = s; th_a = th;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(name);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy_a, done_a, spk_a, acc_a, addr_a} !== '0) begin
            fails++;
            $display("FAIL reset_a: busy=%b done=%b spk=%b acc=%h addr=%h, required all 0",
                     busy_a, done_a, spk_a, acc_a, addr_a);
        end
        tests_run++;
        if ({busy_b, done_b, spk_b, acc_b, addr_b} !== '0) begin
            fails++;
            $display("FAIL reset_b: busy=%b done=%b spk=%b acc=%h addr=%h, required all 0",
                     busy_b, done_b, spk_b, acc_b, addr_b);
        end
    endtask

    task automatic test_basic_fire();
        load_basic_a();
        do_run_a(4'b0011, 9'd3, "basic_th3");
        tests_run++;
        if (acc_a !== 9'd3 || spk_a !== 1'b1) begin
            fails++;
            $display("FAIL basic_th3: acc=%0d spk=%b, required acc=3 spk=1", $signed(acc_a), spk_a);
        end
        do_run_a(4'b0011, 9'd4, "basic_th4");
        tests_run++;
        if (acc_a !== 9'd3 || spk_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_th4: acc=%0d spk=%b, required acc=3 spk=0", $signed(acc_a), spk_a);
        end
    endtask

    task automatic test_cycle_accuracy();
        logic [7:0] exp_addr;
        logic       exp_busy, exp_done;
        load_basic_a();
        @(negedge clk);
        start_a = 1'b1; spikes_a = 4'b1111; th_a = 9'd0;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
            exp_addr = (k < 3) ? 8'(k) : 8'd3;
            exp_busy = (k <= 5);
            exp_done = (k == 6);
            tests_run++;
            if (addr_a !== exp_addr || busy_a !== exp_busy || done_a !== exp_done) begin
                fails++;
                $display("FAIL cycle_E%0d: addr=%0d busy=%b done=%b, required addr=%0d busy=%b done=%b",
                         k, addr_a, busy_a, done_a, exp_addr, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_signed_gating();
        load_basic_a();
        do_run_a(4'b1100, 9'h1FF, "signed");
        tests_run++;
        if (acc_a !== 9'h1FF || spk_a !== 1'b1) begin
            fails++;
            $display("FAIL signed: acc=%0d spk=%b, required acc=-1 spk=1", $signed(acc_a), spk_a);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) ram_a[i] = 8'h7F;
        do_run_a(4'b1111, 9'd0, "sat_pos");
        tests_run++;
        if (acc_a !== 9'h0FF || spk_a !== 1'b1) begin
            fails++;
            $display("FAIL sat_pos: acc=%0d spk=%b, required acc=255 spk=1", $signed(acc_a), spk_a);
        end
        for (int i = 0; i < 4; i++) ram_a[i] = 8'h80;
        do_run_a(4'b1111, 9'd0, "sat_neg");
        tests_run++;
        if (acc_a !== 9'h100 || spk_a !== 1'b0) begin
            fails++;
            $display("FAIL sat_neg: acc=%0d spk=%b, required acc=-256 spk=0", $signed(acc_a), spk_a);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        load_basic_a();
        @(negedge clk);
        start_a = 1'b1; spikes_a = 4'b0011; th_a = 9'd0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) spikes_a = 4'b1100;
            if (done_a) dones++;
            if (k == 6) begin
                tests_run++;
                if (done_a !== 1'b1 || busy_a !== 1'b0 || acc_a !== 9'd3) begin
                    fails++;
                    $display("FAIL b2b_first: done=%b busy=%b acc=%0d, required done=1 busy=0 acc=3",
                             done_a, busy_a, $signed(acc_a));
                end
            end
            if (k == 7) begin
                start_a = 1'b0;
                tests_run++;
                if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_restart: busy=%b done=%b, required busy=1 done=0", busy_a, done_a);
                end
            end
            if (k == 13) begin
                tests_run++;
                if (done_a !== 1'b1 || acc_a !== 9'h1FF) begin
                    fails++;
                    $display("FAIL b2b_second: done=%b acc=%0d, required done=1 acc=-1",
                             done_a, $signed(acc_a));
                end
            end
        end
        tests_run++;
        if (dones !== 2) begin
            fails++;
            $display("FAIL b2b_done_count: %0d pulses, required 2", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        load_basic_a();
        @(negedge clk);
        start_a = 1'b1; spikes_a = 4'b0011; th_a = 9'd3;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy_a, done_a, spk_a, acc_a, addr_a} !== '0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b spk=%b acc=%h addr=%h, required all 0",
                     busy_a, done_a, spk_a, acc_a, addr_a);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_a || busy_a) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL reset_no_done: %0d cycles with done/busy, required 0", dones);
        end
        do_run_a(4'b0011, 9'd3, "reset_rerun");
        tests_run++;
        if (acc_a !== 9'd3 || spk_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_rerun: acc=%0d spk=%b, required acc=3 spk=1", $signed(acc_a), spk_a);
        end
    endtask

    task automatic test_random_wide();
        int          exp_acc, th_int, mode;
        logic [63:0] s;
        logic        exp_spk;
        for (int r = 0; r < 20; r++) begin
            mode = r % 3;
            for (int i = 16; i < 80; i++) begin
                if (mode == 0)      ram_b[i] = 8'($urandom_range(0, 255));
                else if (mode == 1) ram_b[i] = 8'($urandom_range(8'h40, 8'h7F));
                else                ram_b[i] = 8'($urandom_range(8'h80, 8'hC0));
            end
            s = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) s = s & {$urandom, $urandom};
            exp_acc = integrate(s, 64, 16, 12, 1'b1);
            th_int  = exp_acc + int'($urandom_range(0, 6)) - 3;
            if (th_int > 2047) th_int = 2047;
            if (th_int < -2048) th_int = -2048;
            exp_spk = (exp_acc >= th_int);
            @(negedge clk);
            start_b = 1'b1; spikes_b = s; th_b = 12'(th_int);
            @(negedge clk);
            start_b  = 1'b0;
            spikes_b = ~s;
            wait_done_b("rand");
            tests_run++;
            if (acc_b !== 12'(exp_acc) || spk_b !== exp_spk) begin
                fails++;
                $display("FAIL rand_%0d: acc=%0d spk=%b, required acc=%0d spk=%b (th=%0d)",
                         r, $signed(acc_b), spk_b, exp_acc, exp_spk, th_int);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; spikes_a = '0; th_a = '0;
        start_b = 1'b0; spikes_b = '0; th_b = '0;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'h00;
            ram_b[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic_fire();
        test_cycle_accuracy();
        test_signed_gating();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        test_random_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
